// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the decimal-ASCII UART receive path.
//   - ASCII codes recognised by the number parser
//   - byte receiver / echo transmitter state encodings
//   - default bit period (217 clk = 460800 baud at 100 MHz)
// Optional build macro used by the consumers of this package: UART_DEC_ECHO_EN
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int CLKS_PER_BIT_DEF = 217;
    localparam int VALUE_W          = 32;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 byte receiver: 2-FF synchroniser on rx followed by a bit-timing FSM.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-high
//   rx         in   raw serial input, idle high
//   data       out  last received byte (stable until the next byte shifts in)
//   byte_valid out  1-cycle pulse: data holds a byte with a good stop bit
//   frame_err  out  1-cycle pulse: stop bit sampled low, byte discarded
//   busy       out  receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1, sync2, rx_prev;
    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          byte_valid_nxt, frame_err_nxt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            sync2      <= sync1;
            rx_prev    <= sync2;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CW'(1);
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                // Edge rather than level: a line held low after a bad stop
                // bit must not look like a fresh start bit.
                if (!sync2 && rx_prev) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {sync2, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    if (sync2) begin
                        byte_valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RX_IDLE;
            end
        endcase
    end

    assign data = shreg;
    assign busy = (state != RX_IDLE);

endmodule

// File: rtl/uart_dec_rx.sv
// ---------------------------------------------------------------------------
// uart_dec_rx
// Decimal-ASCII UART receiver: deserialises 8N1 bytes, accumulates decimal
// digits into a saturating 32-bit value and publishes it on CR or LF through
// a valid/ack handshake.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active-high
//   rx          in   UART serial input, idle high
//   value       out  decoded binary value
//   value_valid out  value available, held until acknowledged
//   value_ack   in   consumer accepts value
//   overflow    out  value saturated (qualified by value_valid)
//   overrun     out  1-cycle pulse: unacknowledged value overwritten
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   syntax_err  out  1-cycle pulse: illegal character received
//   busy        out  byte receiver not in IDLE
//   tx          out  echo line
// Build option: UART_DEC_ECHO_EN adds an 8N1 transmitter echoing each good
// byte on tx; without it tx is constant 1.
// ---------------------------------------------------------------------------
module uart_dec_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    input  logic               value_ack,
    output logic               overflow,
    output logic               overrun,
    output logic               frame_err,
    output logic               syntax_err,
    output logic               busy,
    output logic               tx
);

    logic [7:0]         rx_data;
    logic               byte_valid;
    logic               rx_frame_err;

    logic [VALUE_W-1:0] acc;
    logic               ovf;
    logic               digit_seen;
    logic               publish;
    logic [VALUE_W:0]   mac;

    // acc*10 + d evaluated 36 bits wide; result is {saturated, value}.
    function automatic logic [VALUE_W:0] sat_mac(input logic [VALUE_W-1:0] a,
                                                 input logic [3:0]         d);
        logic [35:0] wide;
        wide = 36'(a) * 36'd10 + 36'(d);
        if (wide > 36'h0_FFFF_FFFF) begin
            return {1'b1, {VALUE_W{1'b1}}};
        end
        return {1'b0, wide[VALUE_W-1:0]};
    endfunction

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (rx_data),
        .byte_valid(byte_valid),
        .frame_err (rx_frame_err),
        .busy      (busy)
    );

    assign frame_err = rx_frame_err;

    // For '0'..'9' the low nibble is already the digit value.
    assign mac     = sat_mac(acc, rx_data[3:0]);
    assign publish = byte_valid && is_term(rx_data) && digit_seen;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc         <= '0;
            ovf         <= 1'b0;
            digit_seen  <= 1'b0;
            value       <= '0;
            overflow    <= 1'b0;
            value_valid <= 1'b0;
            overrun     <= 1'b0;
            syntax_err  <= 1'b0;
        end else begin
            overrun    <= 1'b0;
            syntax_err <= 1'b0;

            if (rx_frame_err) begin
                acc        <= '0;
                ovf        <= 1'b0;
                digit_seen <= 1'b0;
            end else if (byte_valid) begin
                if (is_digit(rx_data)) begin
                    acc        <= mac[VALUE_W-1:0];
                    ovf        <= ovf | mac[VALUE_W];
                    digit_seen <= 1'b1;
                end else if (is_term(rx_data)) begin
                    // Terminator with no digits (CRLF, blank line) is a no-op.
                    if (digit_seen) begin
                        acc        <= '0;
                        ovf        <= 1'b0;
                        digit_seen <= 1'b0;
                    end
                end else begin
                    syntax_err <= 1'b1;
                    acc        <= '0;
                    ovf        <= 1'b0;
                    digit_seen <= 1'b0;
                end
            end

            // A publish coinciding with ack hands over the old value and
            // loads the new one, so it is not an overrun.
            if (publish) begin
                value       <= acc;
                overflow    <= ovf;
                value_valid <= 1'b1;
                overrun     <= value_valid && !value_ack;
            end else if (value_valid && value_ack) begin
                value_valid <= 1'b0;
            end
        end
    end

`ifdef UART_DEC_ECHO_EN
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_sh, tx_sh_nxt;
    logic          tx_nxt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_sh    <= tx_sh_nxt;
            tx       <= tx_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + CW'(1);
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                if (byte_valid) begin
                    tx_state_nxt = TX_START;
                    tx_sh_nxt    = rx_data;
                    tx_bit_nxt   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    tx_sh_nxt  = {1'b1, tx_sh[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    // A byte landing on the last stop cycle can still be
                    // chained without a gap.
                    if (byte_valid) begin
                        tx_state_nxt = TX_START;
                        tx_sh_nxt    = rx_data;
                        tx_bit_nxt   = '0;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
            end
        endcase

        case (tx_state_nxt)
            TX_START: tx_nxt = 1'b0;
            TX_DATA:  tx_nxt = tx_sh_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_dec_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_dec_rx
// Self-checking bench for uart_dec_rx at CLKS_PER_BIT=16: a table of ASCII
// lines with hand-computed results, plus hand-written sequences for the
// handshake, overrun, glitch, reset and echo cases.
// ---------------------------------------------------------------------------
module tb_uart_dec_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [31:0] value;
    logic        value_valid;
    logic        value_ack;
    logic        overflow;
    logic        overrun;
    logic        frame_err;
    logic        syntax_err;
    logic        busy;
    logic        tx;

    int checks = 0;
    int errors = 0;

    int n_pub = 0, n_syn = 0, n_frm = 0, n_ovr = 0;
    logic vv_q = 1'b0;

    always #5 clk = ~clk;

    uart_dec_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .value      (value),
        .value_valid(value_valid),
        .value_ack  (value_ack),
        .overflow   (overflow),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .syntax_err (syntax_err),
        .busy       (busy),
        .tx         (tx)
    );

    // Event counters, sampled on the inactive edge.
    always @(negedge clk) begin
        vv_q <= value_valid;
        if (value_valid && !vv_q) n_pub <= n_pub + 1;
        if (syntax_err)           n_syn <= n_syn + 1;
        if (frame_err)            n_frm <= n_frm + 1;
        if (overrun)              n_ovr <= n_ovr + 1;
    end

    typedef struct {
        logic [127:0] text;
        int           len;
        int           bad;   // index of byte sent with a low stop bit, -1 none
        int           pub;
        logic [31:0]  val;
        logic         ovf;
        int           syn;
        int           frm;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One 8N1 frame; negedge c of the frame is iteration c. The terminator's
    // publish edge falls right after iteration 155 (2 sync + edge detect +
    // half bit + 9 bits + registered byte_valid).
    task automatic send_byte(input logic [7:0] b, input logic stop_ok,
                             input logic ack_pub);
        int k;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            k = c / CPB;
            if (k == 0)      rx = 1'b0;
            else if (k == 9) rx = stop_ok;
            else             rx = b[k-1];
            if (ack_pub) value_ack = (c == 155);
        end
        rx = 1'b1;
    endtask

    task automatic send_str(input logic [127:0] t, input int len);
        for (int i = 0; i < len; i++) begin
            send_byte(t[8*(len-1-i) +: 8], 1'b1, 1'b0);
        end
    endtask

    task automatic do_ack(input string name);
        @(negedge clk);
        value_ack = 1'b1;
        @(negedge clk);
        value_ack = 1'b0;
        check(name, {31'b0, value_valid}, 32'd0);
    endtask

    int p0, s0, f0, o0;

    initial begin
        vecs[0] = '{"4294967295\012",  11, -1, 1, 32'hFFFF_FFFF, 1'b0, 0, 0};
        vecs[1] = '{"4294967296\012",  11, -1, 1, 32'hFFFF_FFFF, 1'b1, 0, 0};
        vecs[2] = '{"\015\0127\015\012", 5, -1, 1, 32'd7,        1'b0, 0, 0};
        vecs[3] = '{"12a3\015",         5, -1, 1, 32'd3,         1'b0, 1, 0};
        vecs[4] = '{"125\015",          4,  2, 0, 32'd0,         1'b0, 0, 1};
        vecs[5] = '{"8\015",            2, -1, 1, 32'd8,         1'b0, 0, 0};
        vecs[6] = '{"007\015",          4, -1, 1, 32'd7,         1'b0, 0, 0};
        vecs[7] = '{"99999999999\012", 12, -1, 1, 32'hFFFF_FFFF, 1'b1, 0, 0};
        vecs[8] = '{"12x\015",          4, -1, 0, 32'd0,         1'b0, 1, 0};
        vecs[9] = '{"0\015",            2, -1, 1, 32'd0,         1'b0, 0, 0};

        rst_n     = 1'b1;
        rx        = 1'b1;
        value_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", value, 32'd0);
        check("rst_valid", {31'b0, value_valid}, 32'd0);
        check("rst_flags", {26'b0, overflow, overrun, frame_err, syntax_err, busy, tx},
              32'h01);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        // Basic value with a long hold before ack.
        send_str("1234\015", 5);
        repeat (100) @(negedge clk);
        check("hold_valid", {31'b0, value_valid}, 32'd1);
        check("hold_value", value, 32'h0000_04D2);
        check("hold_ovf", {31'b0, overflow}, 32'd0);
        do_ack("hold_ack");

        // Table-driven lines.
        for (int i = 0; i < 10; i++) begin
            p0 = n_pub; s0 = n_syn; f0 = n_frm; o0 = n_ovr;
            for (int j = 0; j < vecs[i].len; j++) begin
                send_byte(vecs[i].text[8*(vecs[i].len-1-j) +: 8], (j != vecs[i].bad), 1'b0);
            end
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_pub", i), n_pub - p0, vecs[i].pub);
            check($sformatf("v%0d_syn", i), n_syn - s0, vecs[i].syn);
            check($sformatf("v%0d_frm", i), n_frm - f0, vecs[i].frm);
            check($sformatf("v%0d_ovr", i), n_ovr - o0, 0);
            if (vecs[i].pub > 0) begin
                check($sformatf("v%0d_value", i), value, vecs[i].val);
                check($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
                do_ack($sformatf("v%0d_ack", i));
            end else begin
                check($sformatf("v%0d_valid", i), {31'b0, value_valid}, 32'd0);
            end
        end

        // Overwrite without ack -> overrun.
        o0 = n_ovr;
        send_str("5\015", 2);
        repeat (20) @(negedge clk);
        check("ovr_first", value, 32'd5);
        send_str("6\015", 2);
        repeat (20) @(negedge clk);
        check("ovr_pulse", n_ovr - o0, 1);
        check("ovr_value", value, 32'd6);
        check("ovr_valid", {31'b0, value_valid}, 32'd1);
        do_ack("ovr_ack");

        // Publish in the same cycle as ack -> no overrun, valid stays.
        o0 = n_ovr;
        send_str("5\015", 2);
        repeat (20) @(negedge clk);
        send_byte("6", 1'b1, 1'b0);
        send_byte(8'h0D, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("sameack_ovr", n_ovr - o0, 0);
        check("sameack_valid", {31'b0, value_valid}, 32'd1);
        check("sameack_value", value, 32'd6);
        do_ack("sameack_ack");

        // Short low glitch on rx.
        p0 = n_pub; s0 = n_syn; f0 = n_frm;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_in", {31'b0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        check("glitch_busy_out", {31'b0, busy}, 32'd0);
        check("glitch_events", (n_pub - p0) + (n_syn - s0) + (n_frm - f0), 0);

        // Reset in the middle of a number and of a byte.
        send_str("77\015", 3);
        repeat (20) @(negedge clk);
        check("prerst_valid", {31'b0, value_valid}, 32'd1);
        send_str("12", 2);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            rx = (c < CPB) ? 1'b0 : ((c / CPB) % 2 == 1);
        end
        check("prerst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b1;
        #1;
        check("midrst_value", value, 32'd0);
        check("midrst_flags", {25'b0, value_valid, overflow, overrun, frame_err,
              syntax_err, busy, tx}, 32'h01);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (20) @(negedge clk);
        p0 = n_pub;
        send_str("\015", 1);
        repeat (20) @(negedge clk);
        check("postrst_nopub", n_pub - p0, 0);
        send_str("3\015", 2);
        repeat (20) @(negedge clk);
        check("postrst_value", value, 32'd3);
        do_ack("postrst_ack");

`ifdef UART_DEC_ECHO_EN
        // Echo of '9' (0x39): start bit mid-point is 4 negedges after the
        // frame ends, then one bit every CPB cycles.
        begin
            logic [7:0] echo_ch;
            echo_ch = 8'h39;
            send_byte(echo_ch, 1'b1, 1'b0);
            repeat (4) @(negedge clk);
            check("echo_start", {31'b0, tx}, 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                check($sformatf("echo_bit%0d", b), {31'b0, tx}, {31'b0, echo_ch[b]});
            end
            repeat (CPB) @(negedge clk);
            check("echo_stop", {31'b0, tx}, 32'd1);
        end
`else
        send_byte("9", 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("noecho_tx", {31'b0, tx}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
